// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC, icache request/stall handshake, IF/ID register and one-entry skid buffer.
// Optional FETCH_PERF_EN macro adds perf_fetch_cnt / perf_stall_cnt counters.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  // icache handshake: a request completes in any cycle with icache_ren=1 and
  // icache_stall=0; icache_addr is held stable from request start to completion.
  output logic        icache_ren,
  output logic [31:0] icache_addr,
  input  logic [31:0] icache_rdata,
  input  logic        icache_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        hold,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [1:0]  dbg_state
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] stale_addr;
  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic        complete;
  logic        outstanding;
  logic        take;

  assign dbg_state = state;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH, S_DISCARD: begin
        if (redirect_valid)
          state_nxt = outstanding ? S_DISCARD : S_FETCH;
        else if (state == S_DISCARD && complete)
          state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Outputs: no new request is started while the skid buffer is occupied
  always_comb begin
    icache_ren  = 1'b0;
    icache_addr = pc;
    case (state)
      S_FETCH:   icache_ren = ~skid_valid;
      S_DISCARD: begin
        icache_ren  = 1'b1;
        icache_addr = stale_addr;
      end
      default: icache_ren = 1'b0;
    endcase
  end

  assign complete    = icache_ren & ~icache_stall;
  assign outstanding = icache_ren & icache_stall;
  assign take        = complete & (state == S_FETCH) & ~redirect_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      stale_addr <= RESET_PC;
      skid_valid <= 1'b0;
      skid_instr <= 32'h0;
      skid_pc    <= 32'h0;
      if_valid   <= 1'b0;
      if_instr   <= NOP_INSTR;
      if_pc      <= 32'h0;
    end else if (state != S_IDLE) begin
      if (redirect_valid) begin
        pc         <= {redirect_pc[31:2], 2'b00};
        if_valid   <= 1'b0;
        if_instr   <= NOP_INSTR;
        skid_valid <= 1'b0;
        // Remember the abandoned address so it stays on the bus until the cache finishes it
        if (outstanding && state == S_FETCH) stale_addr <= pc;
      end else begin
        if (take) pc <= pc + 32'd4;
        if (hold && if_valid) begin
          if (take) begin
            skid_valid <= 1'b1;
            skid_instr <= icache_rdata;
            skid_pc    <= pc;
          end
        end else if (skid_valid) begin
          if_valid   <= 1'b1;
          if_instr   <= skid_instr;
          if_pc      <= skid_pc;
          skid_valid <= 1'b0;
        end else if (take) begin
          if_valid <= 1'b1;
          if_instr <= icache_rdata;
          if_pc    <= pc;
        end else begin
          if_valid <= 1'b0;
          if_instr <= NOP_INSTR;
        end
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= 32'h0;
      perf_stall_cnt <= 32'h0;
    end else begin
      if (take)        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (outstanding) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
